// File: rtl/executor_pkg.sv
// Shared types and helpers for the Tetris game-step scheduler.
//   state_e    : scheduler FSM states
//   pe_cmd_e   : command codes sent to the piece executor
//   score_table: points awarded for a given number of rows cleared at once
package executor_pkg;

    typedef enum logic [2:0] {
        eWait  = 3'd0,
        eSpawn = 3'd1,
        eIdle  = 3'd2,
        eMove  = 3'd3,
        eCheck = 3'd4,
        eOver  = 3'd5
    } state_e;

    // Literals carry a Cmd prefix so they stay distinct from the state names
    // (eSpawn exists in both sets). Encodings match the pe_cmd_o wire codes.
    typedef enum logic [2:0] {
        eCmdLeft   = 3'd0,
        eCmdRight  = 3'd1,
        eCmdRotate = 3'd2,
        eCmdDown   = 3'd3,
        eCmdSpawn  = 3'd4
    } pe_cmd_e;

    // Points for clearing 'rows' rows in one combine: 0,1,3,5 then 8 for 4+.
    function automatic logic [3:0] score_table(input int unsigned rows);
        logic [3:0] pts;
        case (rows)
            0:       pts = 4'd0;
            1:       pts = 4'd1;
            2:       pts = 4'd3;
            3:       pts = 4'd5;
            default: pts = 4'd8;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/executor_sched_mm_mux.sv
// Combinational matrix-memory port mux.
// The owner of the single matrix-memory port is chosen by the scheduler state:
//   eSpawn/eMove -> piece executor, eCheck -> line-clear executor,
//   anything else -> renderer (read only, writes suppressed).
// Ports:
//   state_i                         scheduler state
//   pe_* / ce_*                     executor read/write requests
//   rn_rd_addr_i                    renderer read address
//   mm_*_o                          to matrix memory
//   rn_grant_o                      renderer owns the read port
module executor_sched_mm_mux
    import executor_pkg::*;
#(
    parameter int width_p = 16,
    parameter int aw      = 5
) (
    input  state_e             state_i,
    input  logic [aw-1:0]      pe_rd_addr_i,
    input  logic [aw-1:0]      ce_rd_addr_i,
    input  logic [aw-1:0]      rn_rd_addr_i,
    input  logic [aw-1:0]      pe_wr_addr_i,
    input  logic [aw-1:0]      ce_wr_addr_i,
    input  logic [width_p-1:0] pe_wr_data_i,
    input  logic [width_p-1:0] ce_wr_data_i,
    input  logic               pe_wr_v_i,
    input  logic               ce_wr_v_i,
    output logic [aw-1:0]      mm_read_addr_o,
    output logic [aw-1:0]      mm_write_addr_o,
    output logic [width_p-1:0] mm_write_data_o,
    output logic               mm_write_v_o,
    output logic               rn_grant_o
);

    always_comb begin
        // Renderer owns the port by default; write enable held low.
        mm_read_addr_o  = rn_rd_addr_i;
        mm_write_addr_o = pe_wr_addr_i;
        mm_write_data_o = pe_wr_data_i;
        mm_write_v_o    = 1'b0;
        rn_grant_o      = 1'b1;
        case (state_i)
            eSpawn, eMove: begin
                mm_read_addr_o  = pe_rd_addr_i;
                mm_write_addr_o = pe_wr_addr_i;
                mm_write_data_o = pe_wr_data_i;
                mm_write_v_o    = pe_wr_v_i;
                rn_grant_o      = 1'b0;
            end
            eCheck: begin
                mm_read_addr_o  = ce_rd_addr_i;
                mm_write_addr_o = ce_wr_addr_i;
                mm_write_data_o = ce_wr_data_i;
                mm_write_v_o    = ce_wr_v_i;
                rn_grant_o      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/executor_sched.sv
// Top-level game-step scheduler for the Tetris core.
// Sequences the piece executor and the line-clear executor with one-cycle
// start pulses and done handshakes, latches gravity ticks, keeps score and
// cleared-line counters, and hands the matrix-memory port to whichever agent
// the current state allows.
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   start_i                      start/restart (honoured in eWait/eOver)
//   cmd_v_i, cmd_i, cmd_ready_o  user command handshake
//   tick_i                       gravity tick pulse
//   pe_v_o, pe_cmd_o, pe_done_i, pe_fail_i   piece executor handshake
//   ce_v_o, ce_done_i, ce_combine_i          line-clear executor handshake
//   *_rd_addr_i, *_wr_*_i, mm_*_o, rn_grant_o  memory port arbitration
//   score_o, lines_o, game_over_o            game status
module executor_sched
    import executor_pkg::*;
#(
    parameter int width_p   = 16,
    parameter int height_p  = 32,
    parameter int score_w_p = 16,
    localparam int aw       = $clog2(height_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 cmd_v_i,
    input  logic [1:0]           cmd_i,
    output logic                 cmd_ready_o,
    input  logic                 tick_i,
    output logic                 pe_v_o,
    output logic [2:0]           pe_cmd_o,
    input  logic                 pe_done_i,
    input  logic                 pe_fail_i,
    output logic                 ce_v_o,
    input  logic                 ce_done_i,
    input  logic [aw-1:0]        ce_combine_i,
    input  logic [aw-1:0]        pe_rd_addr_i,
    input  logic [aw-1:0]        ce_rd_addr_i,
    input  logic [aw-1:0]        rn_rd_addr_i,
    input  logic [aw-1:0]        pe_wr_addr_i,
    input  logic [aw-1:0]        ce_wr_addr_i,
    input  logic [width_p-1:0]   pe_wr_data_i,
    input  logic [width_p-1:0]   ce_wr_data_i,
    input  logic                 pe_wr_v_i,
    input  logic                 ce_wr_v_i,
    output logic [aw-1:0]        mm_read_addr_o,
    output logic [aw-1:0]        mm_write_addr_o,
    output logic [width_p-1:0]   mm_write_data_o,
    output logic                 mm_write_v_o,
    output logic                 rn_grant_o,
    output logic [score_w_p-1:0] score_o,
    output logic [score_w_p-1:0] lines_o,
    output logic                 game_over_o
);

    state_e                 state_reg;
    pe_cmd_e                pe_cmd_reg;
    logic                   pe_v_reg;
    logic                   ce_v_reg;
    logic                   tick_pend_reg;
    logic                   tick_pend_next;
    logic [score_w_p-1:0]   score_reg;
    logic [score_w_p-1:0]   lines_reg;
    logic [score_w_p-1:0]   score_next;
    logic [score_w_p-1:0]   lines_next;
    logic [score_w_p:0]     score_sum;
    logic [score_w_p:0]     lines_sum;
    logic                   tick_take;

    // A tick seen in eIdle (latched or arriving now) wins over a user command.
    assign tick_take   = (state_reg == eIdle) && (tick_pend_reg || tick_i);
    assign cmd_ready_o = (state_reg == eIdle) && !tick_take && cmd_v_i;

    always_comb begin
        tick_pend_next = tick_pend_reg;
        case (state_reg)
            eWait, eOver: if (start_i) tick_pend_next = 1'b0;
            // Consuming a latched tick while a new one arrives re-arms the
            // latch; a fresh tick with nothing latched is consumed directly.
            eIdle:        tick_pend_next = tick_pend_reg && tick_i;
            default:      tick_pend_next = tick_pend_reg || tick_i;
        endcase
    end

    // Saturating accumulation: one extra bit catches the carry-out.
    always_comb begin
        score_sum  = {1'b0, score_reg}
                   + (score_w_p+1)'(score_table(32'(ce_combine_i)));
        lines_sum  = {1'b0, lines_reg} + (score_w_p+1)'(ce_combine_i);
        score_next = score_sum[score_w_p] ? '1 : score_sum[score_w_p-1:0];
        lines_next = lines_sum[score_w_p] ? '1 : lines_sum[score_w_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= eWait;
            pe_cmd_reg    <= eCmdSpawn;
            pe_v_reg      <= 1'b0;
            ce_v_reg      <= 1'b0;
            tick_pend_reg <= 1'b0;
            score_reg     <= '0;
            lines_reg     <= '0;
        end else begin
            pe_v_reg      <= 1'b0;
            ce_v_reg      <= 1'b0;
            tick_pend_reg <= tick_pend_next;
            case (state_reg)
                eWait, eOver: begin
                    if (start_i) begin
                        score_reg  <= '0;
                        lines_reg  <= '0;
                        state_reg  <= eSpawn;
                        pe_cmd_reg <= eCmdSpawn;
                        pe_v_reg   <= 1'b1;
                    end
                end
                eSpawn: begin
                    if (pe_done_i) state_reg <= pe_fail_i ? eOver : eIdle;
                end
                eIdle: begin
                    if (tick_take) begin
                        state_reg  <= eMove;
                        pe_cmd_reg <= eCmdDown;
                        pe_v_reg   <= 1'b1;
                    end else if (cmd_v_i) begin
                        state_reg  <= eMove;
                        pe_cmd_reg <= pe_cmd_e'({1'b0, cmd_i});
                        pe_v_reg   <= 1'b1;
                    end
                end
                eMove: begin
                    if (pe_done_i) begin
                        // Only a blocked down move means the piece landed.
                        if (pe_cmd_reg == eCmdDown && pe_fail_i) begin
                            state_reg <= eCheck;
                            ce_v_reg  <= 1'b1;
                        end else begin
                            state_reg <= eIdle;
                        end
                    end
                end
                eCheck: begin
                    if (ce_done_i) begin
                        score_reg  <= score_next;
                        lines_reg  <= lines_next;
                        state_reg  <= eSpawn;
                        pe_cmd_reg <= eCmdSpawn;
                        pe_v_reg   <= 1'b1;
                    end
                end
                default: state_reg <= eWait;
            endcase
        end
    end

    assign pe_v_o      = pe_v_reg;
    assign ce_v_o      = ce_v_reg;
    assign pe_cmd_o    = pe_cmd_reg;
    assign score_o     = score_reg;
    assign lines_o     = lines_reg;
    assign game_over_o = (state_reg == eOver);

    executor_sched_mm_mux #(
        .width_p (width_p),
        .aw      (aw)
    ) u_mm_mux (
        .state_i         (state_reg),
        .pe_rd_addr_i    (pe_rd_addr_i),
        .ce_rd_addr_i    (ce_rd_addr_i),
        .rn_rd_addr_i    (rn_rd_addr_i),
        .pe_wr_addr_i    (pe_wr_addr_i),
        .ce_wr_addr_i    (ce_wr_addr_i),
        .pe_wr_data_i    (pe_wr_data_i),
        .ce_wr_data_i    (ce_wr_data_i),
        .pe_wr_v_i       (pe_wr_v_i),
        .ce_wr_v_i       (ce_wr_v_i),
        .mm_read_addr_o  (mm_read_addr_o),
        .mm_write_addr_o (mm_write_addr_o),
        .mm_write_data_o (mm_write_data_o),
        .mm_write_v_o    (mm_write_v_o),
        .rn_grant_o      (rn_grant_o)
    );

endmodule
